// File: rtl/i2s_dac_tx_if.sv
// Sample-side and codec-side signals of the I2S DAC transmitter.
// The master modport is the transmitter; the slave modport is its environment.
interface i2s_dac_tx_if #(
    parameter int unsigned SAMPLE_W = 16
);
    logic                INIT_FINISH;
    logic [SAMPLE_W-1:0] LDATA;
    logic [SAMPLE_W-1:0] RDATA;
    logic                data_over;
    logic                AUD_BCLK;
    logic                AUD_DACLRCK;
    logic                AUD_DACDAT;

    modport master (
        input  INIT_FINISH,
        input  LDATA,
        input  RDATA,
        output data_over,
        output AUD_BCLK,
        output AUD_DACLRCK,
        output AUD_DACDAT
    );

    modport slave (
        output INIT_FINISH,
        output LDATA,
        output RDATA,
        input  data_over,
        input  AUD_BCLK,
        input  AUD_DACLRCK,
        input  AUD_DACDAT
    );
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the WM8731 DAC: bus master for BCLK/LRCK, shifts a latched
// stereo sample pair out MSB first and pulses data_over once per frame.
module i2s_dac_tx #(
    parameter int unsigned CLK_DIV  = 8,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned SLOT_W   = 32
) (
    input logic         Clk,
    input logic         Reset,
    i2s_dac_tx_if.master bus
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DivLast = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(2 * SLOT_W - 1);
    localparam logic [CNT_W-1:0] CntSlot = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] CntLEnd = CNT_W'(SAMPLE_W);
    localparam logic [CNT_W-1:0] CntREnd = CNT_W'(SLOT_W + SAMPLE_W);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [SAMPLE_W-1:0] r_ldata;
    logic [SAMPLE_W-1:0] r_rdata;
    logic                r_bclk;
    logic                r_lrck;
    logic                r_dat;
    logic                r_data_over;

    logic             w_div_tc;
    logic [CNT_W-1:0] w_bit_nxt;
    logic             w_in_left;
    logic             w_in_right;

    assign w_div_tc   = (r_div == DivLast);
    assign w_bit_nxt  = (r_bit_cnt == CntLast) ? '0 : r_bit_cnt + 1'b1;
    // One-bit I2S delay: slot bit 0 is always a zero pad after the LRCK edge.
    assign w_in_left  = (w_bit_nxt != '0) && (w_bit_nxt <= CntLEnd);
    assign w_in_right = (w_bit_nxt > CntSlot) && (w_bit_nxt <= CntREnd);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= StIdle;
            r_div       <= '0;
            r_bit_cnt   <= '0;
            r_ldata     <= '0;
            r_rdata     <= '0;
            r_bclk      <= 1'b0;
            r_lrck      <= 1'b0;
            r_dat       <= 1'b0;
            r_data_over <= 1'b0;
        end else begin
            r_data_over <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_bclk <= 1'b0;
                    r_lrck <= 1'b0;
                    r_dat  <= 1'b0;
                    if (bus.INIT_FINISH) begin
                        r_state     <= StRun;
                        r_ldata     <= bus.LDATA;
                        r_rdata     <= bus.RDATA;
                        r_bit_cnt   <= '0;
                        r_div       <= '0;
                        r_data_over <= 1'b1;
                    end
                end
                StRun: begin
                    if (w_div_tc) begin
                        r_div  <= '0;
                        r_bclk <= ~r_bclk;
                        if (r_bclk) begin
                            r_bit_cnt <= w_bit_nxt;
                            r_lrck    <= (w_bit_nxt >= CntSlot);
                            r_dat     <= 1'b0;
                            if (w_in_left) begin
                                r_dat   <= r_ldata[SAMPLE_W-1];
                                r_ldata <= r_ldata << 1;
                            end else if (w_in_right) begin
                                r_dat   <= r_rdata[SAMPLE_W-1];
                                r_rdata <= r_rdata << 1;
                            end
                            // INIT_FINISH only matters at the frame boundary.
                            if (w_bit_nxt == '0) begin
                                if (bus.INIT_FINISH) begin
                                    r_ldata     <= bus.LDATA;
                                    r_rdata     <= bus.RDATA;
                                    r_data_over <= 1'b1;
                                end else begin
                                    r_state <= StDrain;
                                end
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                StDrain: begin
                    r_bclk  <= 1'b0;
                    r_lrck  <= 1'b0;
                    r_dat   <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.data_over   = r_data_over;
    assign bus.AUD_BCLK    = r_bclk;
    assign bus.AUD_DACLRCK = r_lrck;
    assign bus.AUD_DACDAT  = r_dat;
endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx: cycle-level frame-time reference model plus
// an independent serial decoder that reassembles each frame from BCLK rising edges.
module tb_i2s_dac_tx;
    localparam int CLK_DIV  = 8;
    localparam int SAMPLE_W = 16;
    localparam int SLOT_W   = 32;
    localparam int Frame    = 4 * SLOT_W * CLK_DIV;

    logic Clk;
    logic rst_n;

    i2s_dac_tx_if #(.SAMPLE_W(SAMPLE_W)) bus ();

    i2s_dac_tx #(
        .CLK_DIV (CLK_DIV),
        .SAMPLE_W(SAMPLE_W),
        .SLOT_W  (SLOT_W)
    ) dut (
        .Clk  (Clk),
        .Reset(rst_n),
        .bus  (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: mode 0 idle, 1 running, 2 draining; m_n = cycles since latch.
    int          m_mode = 0;
    int          m_n    = 0;
    logic [15:0] m_l    = '0;
    logic [15:0] m_r    = '0;

    // Decoder / controller-emulation state.
    logic        prev_bclk = 1'b0;
    logic [63:0] cap       = '0;
    int          rises     = 0;
    int          last_do   = -1;
    bit          idx_mode  = 1'b0;
    int unsigned idx       = 0;
    int          do_count  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_mode = 0;
            m_n    = 0;
            return;
        end
        case (m_mode)
            0: if (bus.INIT_FINISH) begin
                m_mode = 1;
                m_n    = 0;
                m_l    = bus.LDATA;
                m_r    = bus.RDATA;
            end
            1: begin
                m_n++;
                if (m_n == Frame) begin
                    if (bus.INIT_FINISH) begin
                        m_n = 0;
                        m_l = bus.LDATA;
                        m_r = bus.RDATA;
                    end else begin
                        m_mode = 2;
                    end
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic model_expect(output logic e_bclk, output logic e_lrck,
                                output logic e_dat, output logic e_do);
        int          c;
        logic [15:0] sh;
        e_bclk = 1'b0;
        e_lrck = 1'b0;
        e_dat  = 1'b0;
        e_do   = 1'b0;
        if (m_mode == 1) begin
            c      = m_n / (2 * CLK_DIV);
            e_bclk = ((m_n / CLK_DIV) % 2) == 1;
            e_lrck = c >= SLOT_W;
            e_do   = m_n == 0;
            if (c >= 1 && c <= SAMPLE_W) begin
                sh    = m_l >> (SAMPLE_W - c);
                e_dat = sh[0];
            end else if (c >= SLOT_W + 1 && c <= SLOT_W + SAMPLE_W) begin
                sh    = m_r >> (SLOT_W + SAMPLE_W - c);
                e_dat = sh[0];
            end
        end
    endtask

    task automatic monitor();
        logic [63:0] mask;
        if (!rst_n || m_mode != 1) begin
            rises   = 0;
            last_do = -1;
        end
        if (!prev_bclk && bus.AUD_BCLK) begin
            cap = {cap[62:0], bus.AUD_DACDAT};
            rises++;
            if (rises == 2 * SLOT_W) begin
                mask = 64'h7FFF_8000_7FFF_8000;
                check_eq("frame_left", 64'(cap[62:47]), 64'(m_l));
                check_eq("frame_right", 64'(cap[30:15]), 64'(m_r));
                check_eq("frame_pad_zero", cap & ~mask, 64'd0);
                if (idx_mode)
                    check_eq("left_is_prev_idx", 64'(cap[62:47]), 64'(16'(idx - 1)));
            end
        end
        if (bus.data_over) begin
            rises = 0;
            if (last_do >= 0) check_eq("do_period", 64'(cyc - last_do), 64'(Frame));
            last_do = cyc;
            do_count++;
            if (idx_mode) begin
                idx++;
                bus.LDATA = 16'(idx);
            end
        end
        prev_bclk = bus.AUD_BCLK;
    endtask

    task automatic tick();
        logic e_bclk, e_lrck, e_dat, e_do;
        @(posedge Clk);
        model_edge();
        cyc++;
        #1;
        model_expect(e_bclk, e_lrck, e_dat, e_do);
        check_eq("bclk", 64'(bus.AUD_BCLK), 64'(e_bclk));
        check_eq("lrck", 64'(bus.AUD_DACLRCK), 64'(e_lrck));
        check_eq("dacdat", 64'(bus.AUD_DACDAT), 64'(e_dat));
        check_eq("data_over", 64'(bus.data_over), 64'(e_do));
        monitor();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_do(input int budget);
        int k;
        k = 0;
        while (!bus.data_over && k < budget) begin
            tick();
            k++;
        end
        if (!bus.data_over) check_eq("wait_do_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.INIT_FINISH = 1'b1;
        bus.LDATA       = 16'hFFFF;
        bus.RDATA       = 16'hFFFF;

        // Held in reset: everything quiet despite INIT_FINISH.
        ticks(5);

        rst_n     = 1'b1;
        bus.LDATA = 16'hA5C3;
        bus.RDATA = 16'h0F0F;
        ticks(2 * Frame + 10);

        // Mid-frame LDATA change must not disturb the frame in flight.
        wait_do(Frame + 10);
        ticks(299);
        bus.LDATA = 16'h1234;
        ticks(2 * Frame);

        // INIT_FINISH drop mid-frame: frame completes, then drain and idle.
        wait_do(Frame + 10);
        ticks(499);
        bus.INIT_FINISH = 1'b0;
        ticks(Frame);
        bus.INIT_FINISH = 1'b1;
        ticks(Frame + 40);

        // Reset mid-frame, then restart.
        wait_do(Frame + 10);
        ticks(699);
        rst_n = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        ticks(Frame + 40);

        // Playback-sequencer emulation: LDATA follows an index bumped on data_over.
        rst_n = 1'b0;
        ticks(2);
        idx       = $urandom_range(16'hFFF0);
        bus.LDATA = 16'(idx);
        bus.RDATA = 16'($urandom);
        do_count  = 0;
        idx_mode  = 1'b1;
        rst_n     = 1'b1;
        ticks(10 * Frame - 5);
        check_eq("do_count_10_frames", 64'(do_count), 64'd10);
        idx_mode = 1'b0;

        // Randomized traffic: sample churn, occasional INIT_FINISH drops and resets.
        for (int i = 0; i < 9000; i++) begin
            tick();
            if ($urandom_range(63) == 0) bus.LDATA = 16'($urandom);
            if ($urandom_range(63) == 0) bus.RDATA = 16'($urandom);
            if (bus.INIT_FINISH) begin
                if ($urandom_range(2999) == 0) bus.INIT_FINISH = 1'b0;
            end else if ($urandom_range(199) == 0) begin
                bus.INIT_FINISH = 1'b1;
            end
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(4999) == 0) rst_n = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
